// File: rtl/hp_tx_serializer.sv
// hp_tx_serializer
//   Transmit side of the HP dock. Accepts 8-bit words on a valid/ready interface,
//   buffers them in a small FIFO and shifts them out one bit per div_clk on tx_bit,
//   which drives the dock's swing_in. Back-to-back words leave with no gap bit.
//   Flags a sticky underrun when the stream breaks while enabled and counts sent words.

module hp_tx_serializer #(
   parameter int unsigned FIFO_DEPTH = 4,     // power of 2, >= 2
   parameter bit          MSB_FIRST  = 1'b1,  // 1: bit7 leaves first, 0: bit0 first
   parameter logic        IDLE_LEVEL = 1'b0,  // tx_bit level while nothing is shifted
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned AW = $clog2(FIFO_DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic             div_clk,
   input  logic             free_run_rst_n,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             enable,
   input  logic             clear_underrun,
   output logic             tx_bit,
   output logic             busy,
   output logic             underrun,
   output logic [LW-1:0]    fifo_level,
   output logic [CNT_W-1:0] words_sent
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    count_q;
   logic             full, empty, push, pop;

   logic [7:0]       sreg_q;
   logic [2:0]       bit_cnt_q;
   logic [CNT_W-1:0] words_sent_q;
   logic             underrun_q;

   logic             load, shift, word_done, set_underrun;

   assign full  = (count_q == LW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = tx_valid && !full;
   // Pops come only from the registered FIFO state, so a word written into an
   // empty FIFO is never consumed in the same cycle.
   assign pop   = load;

   // Next state and per-cycle control for the shifter.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      state_d      = state_q;
      load         = 1'b0;
      shift        = 1'b0;
      word_done    = 1'b0;
      set_underrun = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && !empty) begin
               load    = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_cnt_q == 3'd7) begin
               word_done = 1'b1;
               if (enable && !empty) begin
                  load = 1'b1;              // next word follows with no gap bit
               end else begin
                  state_d      = S_IDLE;
                  set_underrun = enable;    // a deliberate stop is not an underrun
               end
            end else begin
               shift = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge div_clk or negedge free_run_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!free_run_rst_n) state_q <= S_IDLE;
      else                 state_q <= state_d;
   end

   // FIFO word storage.
   always_ff @(posedge div_clk) begin
      // NOTE: the storage array has no reset; validity is tracked by count_q and
      // the pointers, so stale words are never observed.
      if (push) mem[wr_ptr_q] <= tx_data;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
   always_ff @(posedge div_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + LW'(1);
            2'b01:   count_q <= count_q - LW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Shift register and bit counter for the word on the wire.
   always_ff @(posedge div_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
      end else if (load) begin
         sreg_q    <= mem[rd_ptr_q];
         bit_cnt_q <= '0;
      end else if (shift) begin
         sreg_q    <= MSB_FIRST ? {sreg_q[6:0], 1'b0} : {1'b0, sreg_q[7:1]};
         bit_cnt_q <= bit_cnt_q + 3'd1;
      end else if (word_done) begin
         bit_cnt_q <= '0;
      end
   end

   // Count of fully shifted words; wraps naturally.
   always_ff @(posedge div_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n)  words_sent_q <= '0;
      else if (word_done)   words_sent_q <= words_sent_q + CNT_W'(1);
   end

   // Sticky underrun flag; a set in the same cycle as a clear wins.
   always_ff @(posedge div_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n)     underrun_q <= 1'b0;
      else if (set_underrun)   underrun_q <= 1'b1;
      else if (clear_underrun) underrun_q <= 1'b0;
   end

   // tx_bit is taken straight from registers, so an async reset forces the
   // idle level at once without waiting for an edge.
   assign tx_bit     = (state_q == S_SHIFT) ? (MSB_FIRST ? sreg_q[7] : sreg_q[0])
                                            : IDLE_LEVEL;
   assign tx_ready   = !full;
   assign busy       = (state_q == S_SHIFT);
   assign underrun   = underrun_q;
   assign fifo_level = count_q;
   assign words_sent = words_sent_q;

endmodule

// File: tb/tb_hp_tx_serializer.sv
// tb_hp_tx_serializer
//   Directed bench for hp_tx_serializer. A second instance with MSB_FIRST=0 shares
//   all inputs so bit order can be compared word for word.

module tb_hp_tx_serializer;

   logic        div_clk = 1'b0;
   logic        free_run_rst_n;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        enable;
   logic        clear_underrun;

   logic        tx_ready, tx_bit, busy, underrun;
   logic [2:0]  fifo_level;
   logic [15:0] words_sent;

   logic        l_tx_ready, l_tx_bit, l_busy, l_underrun;
   logic [2:0]  l_fifo_level;
   logic [15:0] l_words_sent;

   int vectors     = 0;
   int miscompares = 0;

   always #5 div_clk = ~div_clk;

   hp_tx_serializer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .CNT_W(16)) u_dut (
      .div_clk        (div_clk),
      .free_run_rst_n (free_run_rst_n),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .enable         (enable),
      .clear_underrun (clear_underrun),
      .tx_bit         (tx_bit),
      .busy           (busy),
      .underrun       (underrun),
      .fifo_level     (fifo_level),
      .words_sent     (words_sent)
   );

   hp_tx_serializer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .CNT_W(16)) u_lsb (
      .div_clk        (div_clk),
      .free_run_rst_n (free_run_rst_n),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (l_tx_ready),
      .enable         (enable),
      .clear_underrun (clear_underrun),
      .tx_bit         (l_tx_bit),
      .busy           (l_busy),
      .underrun       (l_underrun),
      .fifo_level     (l_fifo_level),
      .words_sent     (l_words_sent)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge div_clk);
      #1;
   endtask

   // Sample n bits of both instances, one per cycle, first bit ending up as the MSB.
   task automatic collect(input int n, output logic [31:0] bits, output logic [31:0] lbits);
      bits  = '0;
      lbits = '0;
      for (int i = 0; i < n; i++) begin
         bits  = {bits[30:0], tx_bit};
         lbits = {lbits[30:0], l_tx_bit};
         tick();
      end
   endtask

   task automatic do_reset();
      tx_valid       = 1'b0;
      tx_data        = 8'h00;
      enable         = 1'b0;
      clear_underrun = 1'b0;
      free_run_rst_n = 1'b0;
      repeat (3) @(posedge div_clk);
      #2;
      check("rst_tx_bit",     32'(tx_bit),     32'h0);
      check("rst_tx_ready",   32'(tx_ready),   32'h1);
      check("rst_fifo_level", 32'(fifo_level), 32'h0);
      check("rst_words_sent", 32'(words_sent), 32'h0);
      check("rst_underrun",   32'(underrun),   32'h0);
      check("rst_busy",       32'(busy),       32'h0);
      @(negedge div_clk);
      free_run_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b, lb, c1, c2, lc;
      logic        b23, b22;

      // Reset values
      free_run_rst_n = 1'b0;
      do_reset();

      // Single word 8'hA5, enabled
      enable   = 1'b1;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      tick();                                   // after E: word buffered, not popped yet
      tx_valid = 1'b0;
      check("sw_idle_tx_bit", 32'(tx_bit),     32'h0);
      check("sw_idle_busy",   32'(busy),       32'h0);
      check("sw_level_E",     32'(fifo_level), 32'h1);
      tick();                                   // after E+1: first bit out
      check("sw_busy_E1",     32'(busy),       32'h1);
      check("sw_level_E1",    32'(fifo_level), 32'h0);
      collect(8, b, lb);                        // bits after E+1..E+8
      check("sw_bits",        b,               32'hA5);
      check("sw_end_tx_bit",  32'(tx_bit),     32'h0);
      check("sw_end_busy",    32'(busy),       32'h0);
      check("sw_words_sent",  32'(words_sent), 32'h1);
      check("sw_underrun",    32'(underrun),   32'h1);
      clear_underrun = 1'b1;
      tick();
      clear_underrun = 1'b0;
      check("sw_underrun_clr", 32'(underrun),  32'h0);

      // Back-to-back F0, 0F, AA written while enabled
      do_reset();
      enable   = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hF0;
      tick();                                   // E
      tx_data  = 8'h0F;
      tick();                                   // E+1
      b23      = tx_bit;
      tx_data  = 8'hAA;
      tick();                                   // E+2
      tx_valid = 1'b0;
      b22      = tx_bit;
      tick();                                   // E+3
      collect(22, b, lb);                       // E+3..E+24
      check("b2b_bits",       {8'h00, b23, b22, b[21:0]}, 32'h00F00FAA);
      check("b2b_words_sent", 32'(words_sent), 32'h3);
      check("b2b_busy_end",   32'(busy),       32'h0);
      check("b2b_underrun",   32'(underrun),   32'h1);
      check("b2b_level",      32'(fifo_level), 32'h0);

      // Full FIFO: five writes while disabled, the fifth is dropped
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tx_data  = 8'(17 * (i + 1));
         tx_valid = 1'b1;
         check($sformatf("full_ready_%0d", i), 32'(tx_ready), (i < 4) ? 32'h1 : 32'h0);
         tick();
      end
      tx_valid = 1'b0;
      check("full_level",     32'(fifo_level), 32'h4);
      check("full_ready",     32'(tx_ready),   32'h0);
      check("full_busy",      32'(busy),       32'h0);
      enable = 1'b1;
      tick();                                   // S: first word loaded
      collect(32, b, lb);
      check("full_bits",      b,               32'h11223344);
      check("full_words",     32'(words_sent), 32'h4);
      check("full_level_end", 32'(fifo_level), 32'h0);
      check("full_busy_end",  32'(busy),       32'h0);
      check("full_ready_end", 32'(tx_ready),   32'h1);

      // Enable dropped at bit 3 of 8'h81 with 8'h7E queued
      do_reset();
      enable   = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      tick();                                   // E
      tx_data  = 8'h7E;
      tick();                                   // E+1: 81 loaded, 7E written
      tx_valid = 1'b0;
      collect(3, c1, lc);                       // bits 0..2
      enable = 1'b0;                            // during bit 3
      collect(5, c2, lc);                       // bits 3..7
      check("ed_bits",        {24'h0, c1[2:0], c2[4:0]}, 32'h81);
      check("ed_busy",        32'(busy),       32'h0);
      check("ed_underrun",    32'(underrun),   32'h0);
      check("ed_level",       32'(fifo_level), 32'h1);
      check("ed_words",       32'(words_sent), 32'h1);
      repeat (3) tick();
      check("ed_still_idle",  32'(busy),       32'h0);
      check("ed_still_level", 32'(fifo_level), 32'h1);
      enable         = 1'b1;
      clear_underrun = 1'b1;                    // held across the set: set must win
      tick();                                   // 7E loaded
      collect(8, b, lb);
      clear_underrun = 1'b0;
      check("ed_resend_bits", b,               32'h7E);
      check("ed_words_2",     32'(words_sent), 32'h2);
      check("ed_set_wins",    32'(underrun),   32'h1);

      // Async reset in the middle of a word
      do_reset();
      enable   = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick();                                   // E
      tx_valid = 1'b0;
      repeat (5) tick();                        // after E+5: bit 4 on the wire
      check("ar_bit4",        32'(tx_bit),     32'h1);
      check("ar_lsb_bit4",    32'(l_tx_bit),   32'h1);
      #2;
      free_run_rst_n = 1'b0;
      #1;                                       // no clock edge in between
      check("ar_tx_bit",      32'(tx_bit),     32'h0);
      check("ar_lsb_tx_bit",  32'(l_tx_bit),   32'h0);
      check("ar_busy",        32'(busy),       32'h0);
      check("ar_level",       32'(fifo_level), 32'h0);
      check("ar_words",       32'(words_sent), 32'h0);
      @(negedge div_clk);
      free_run_rst_n = 1'b1;
      tick();
      check("ar_level_post",  32'(fifo_level), 32'h0);
      check("ar_busy_post",   32'(busy),       32'h0);
      tx_valid = 1'b1;
      tx_data  = 8'h01;
      tick();                                   // E
      tx_valid = 1'b0;
      tick();                                   // E+1: first bit
      check("ord_msb_first",  32'(tx_bit),     32'h0);
      check("ord_lsb_first",  32'(l_tx_bit),   32'h1);
      collect(8, b, lb);
      check("ord_msb_bits",   b,               32'h01);
      check("ord_lsb_bits",   lb,              32'h80);
      check("ord_lsb_words",  32'(l_words_sent), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
